// File: rtl/uart_word_tx.sv
// Serial word transmitter: sends a BYTES-wide sample word LSB byte first.
// It skips disabled byte groups, adds optional parity and 1 or 2 stop bits, and honours XON/XOFF between bytes.
module uart_word_tx #(
   parameter int unsigned FREQ      = 100000000,
   parameter int unsigned BAUDRATE  = 115200,
   parameter int unsigned BITLENGTH = FREQ / BAUDRATE,
   parameter int unsigned BYTES     = 4,
   parameter logic [31:0] ID_WORD   = 32'h534c4131
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [BYTES-1:0]     disabledGroups,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   input  logic                 write,
   input  logic [8*BYTES-1:0]   wrdata,
   input  logic                 id,
   input  logic                 xon,
   input  logic                 xoff,
   output logic                 tx,
   output logic                 busy
);

   localparam int unsigned W  = 8 * BYTES;
   localparam int unsigned DW = $clog2(BITLENGTH + 1);
   localparam int unsigned IW = $clog2(BYTES + 1);
   localparam logic [W-1:0] ID_EXT = W'(ID_WORD);

   typedef enum logic [1:0] {IDLE, NEXT, LOAD, SHIFT} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   word_q, word_d;
   logic [BYTES-1:0] mask_q, mask_d;
   logic [1:0]     pm_q, pm_d;
   logic           ts_q, ts_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [DW-1:0]  div_q, div_d;
   logic [3:0]     nbits_q, nbits_d;
   logic [12:0]    shreg_q, shreg_d;
   logic           paused_q, paused_d;
   logic           busy_q, busy_d;

   logic [W-1:0]   word_sh;
   logic [7:0]     cur_byte;
   logic           skip, par_en, par_bit;
   logic [12:0]    frame;
   logic [3:0]     last_bit;

   // Current byte and its frame, derived from the byte index.
   always_comb begin
      word_sh  = word_q >> {idx_q, 3'b000};
      cur_byte = word_sh[7:0];
      skip     = |(mask_q & (BYTES'(1) << idx_q));
      par_en   = (pm_q == 2'b01) || (pm_q == 2'b10);
      par_bit  = (pm_q == 2'b01) ? ~^cur_byte : ^cur_byte;
      frame    = '1;
      frame[0] = 1'b0;
      frame[8:1] = cur_byte;
      if (par_en) frame[9] = par_bit;
      last_bit = 4'd9 + {3'b000, par_en} + {3'b000, ts_q};
   end

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      mask_d   = mask_q;
      pm_d     = pm_q;
      ts_d     = ts_q;
      idx_d    = idx_q;
      div_d    = div_q;
      nbits_d  = nbits_q;
      shreg_d  = shreg_q;
      paused_d = xoff | (paused_q & ~xon);
      busy_d   = (state_q != IDLE) | write | id | paused_q;
      case (state_q)
         IDLE: begin
            idx_d  = '0;
            word_d = wrdata;
            mask_d = disabledGroups;
            pm_d   = parity_mode;
            ts_d   = two_stop;
            if (write) begin
               state_d = NEXT;
            end else if (id) begin
               word_d  = ID_EXT;
               mask_d  = '0;
               state_d = NEXT;
            end
         end
         NEXT: begin
            if (idx_q == IW'(BYTES))   state_d = IDLE;
            else if (skip)             idx_d   = idx_q + 1'b1;
            else if (!paused_q)        state_d = LOAD;
         end
         LOAD: begin
            shreg_d = frame;
            nbits_d = last_bit;
            div_d   = DW'(BITLENGTH - 1);
            idx_d   = idx_q + 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            // nbits_q counts bits still to follow the one on the line.
            if (div_q == '0) begin
               if (nbits_q == '0) begin
                  shreg_d = '1;
                  state_d = NEXT;
               end else begin
                  shreg_d = {1'b1, shreg_q[12:1]};
                  nbits_d = nbits_q - 1'b1;
                  div_d   = DW'(BITLENGTH - 1);
               end
            end else begin
               div_d = div_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         word_q   <= '0;
         mask_q   <= '0;
         pm_q     <= '0;
         ts_q     <= 1'b0;
         idx_q    <= '0;
         div_q    <= '0;
         nbits_q  <= '0;
         shreg_q  <= '1;
         paused_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         mask_q   <= mask_d;
         pm_q     <= pm_d;
         ts_q     <= ts_d;
         idx_q    <= idx_d;
         div_q    <= div_d;
         nbits_q  <= nbits_d;
         shreg_q  <= shreg_d;
         paused_q <= paused_d;
         busy_q   <= busy_d;
      end
   end

   assign tx   = shreg_q[0];
   assign busy = busy_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: line-level model (queues of bytes and line levels) checked every cycle,
// plus literal frame/latency expectations decoded from recorded traces.
module tb_uart_word_tx;

   localparam int BL = 4;
   localparam int NB = 4;
   localparam logic [31:0] IDW = 32'h534c4131;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [NB-1:0] disabledGroups = '0;
   logic [1:0]    parity_mode = '0;
   logic          two_stop = 1'b0;
   logic          write = 1'b0;
   logic [8*NB-1:0] wrdata = '0;
   logic          id = 1'b0;
   logic          xon = 1'b0;
   logic          xoff = 1'b0;
   logic          tx;
   logic          busy;

   uart_word_tx #(.FREQ(400), .BAUDRATE(100), .BYTES(NB)) dut (
      .clock(clock), .reset(reset), .disabledGroups(disabledGroups),
      .parity_mode(parity_mode), .two_stop(two_stop), .write(write),
      .wrdata(wrdata), .id(id), .xon(xon), .xoff(xoff), .tx(tx), .busy(busy)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail < 40) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct { bit skip; bit [7:0] data; } byte_t;
   byte_t    m_bytes[$];
   bit       m_line[$];
   bit       m_inw, m_paused, m_busy, m_haveload, m_ts;
   bit [7:0] m_ld;
   bit [1:0] m_pm;

   function automatic void model_clear();
      m_bytes.delete(); m_line.delete();
      m_inw = 0; m_paused = 0; m_busy = 0; m_haveload = 0;
   endfunction

   function automatic void push_frame(bit [7:0] d);
      bit lv[$];
      lv.push_back(1'b0);
      for (int k = 0; k < 8; k++) lv.push_back(d[k]);
      if (m_pm == 2'b01) lv.push_back(($countones(d) % 2) == 0);
      else if (m_pm == 2'b10) lv.push_back(($countones(d) % 2) == 1);
      lv.push_back(1'b1);
      if (m_ts) lv.push_back(1'b1);
      foreach (lv[k]) repeat (BL) m_line.push_back(lv[k]);
   endfunction

   function automatic void model_step();
      bit p_old, inw_old;
      byte_t b;
      p_old   = m_paused;
      inw_old = m_inw;
      m_busy   = inw_old | write | id | p_old;
      m_paused = xoff | (p_old & ~xon);
      if (!inw_old) begin
         if (write | id) begin
            m_inw = 1; m_pm = parity_mode; m_ts = two_stop;
            for (int unsigned i = 0; i < NB; i++) begin
               b.data = write ? wrdata[8*i +: 8] : IDW[8*i +: 8];
               b.skip = write ? disabledGroups[i] : 1'b0;
               m_bytes.push_back(b);
            end
         end
      end else if (m_line.size() != 0) begin
         void'(m_line.pop_front());
      end else if (m_haveload) begin
         push_frame(m_ld);
         m_haveload = 0;
      end else if (m_bytes.size() == 0) begin
         m_inw = 0;
      end else if (m_bytes[0].skip) begin
         void'(m_bytes.pop_front());
      end else if (!p_old) begin
         b = m_bytes.pop_front();
         m_ld = b.data;
         m_haveload = 1;
      end
   endfunction

   initial begin
      model_clear();
      forever begin
         @(posedge clock);
         if (!reset) model_clear();
         else model_step();
         #1;
         check("model_tx", tx, (m_line.size() != 0) ? m_line[0] : 1'b1);
         check("model_busy", busy, m_busy);
      end
   end

   // ---------------- stimulus and trace ----------------
   bit tr_tx[0:4199];
   bit tr_busy[0:4199];
   int ncyc;
   bit [7:0] dec[$];

   task automatic run_word(input logic [31:0] data, input logic [3:0] mask, input logic [1:0] pm,
                           input bit ts, input bit do_wr, input bit do_id, input int xoff_c,
                           input int xon_c, input int both_c, input int rst_c, input bit noise);
      int c;
      bit done;
      wrdata = data; disabledGroups = mask; parity_mode = pm; two_stop = ts;
      write = do_wr; id = do_id;
      c = 0; done = 0;
      while (!done) begin
         @(negedge clock);
         c++;
         write = 0; id = 0;
         xon  = (c == xon_c)  || (c == both_c);
         xoff = (c == xoff_c) || (c == both_c);
         if (noise && c < 1500) begin
            write = ($urandom % 60) == 0;
            id    = ($urandom % 80) == 0;
            xoff  = ($urandom % 150) == 0;
            xon   = ($urandom % 30) == 0;
            wrdata = $urandom; disabledGroups = $urandom;
            parity_mode = $urandom; two_stop = $urandom;
         end else if (noise) begin
            xon = 1;
         end
         tr_tx[c] = tx; tr_busy[c] = busy;
         if (c == rst_c) begin
            reset = 0;
            #1;
            check("async_rst_tx", tx, 1);
            check("async_rst_busy", busy, 0);
            xon = 0; xoff = 0;
            repeat (2) @(negedge clock);
            reset = 1;
            done = 1;
         end else if (c > 2 && busy == 0) begin
            done = 1;
         end else if (c >= 4000) begin
            check("word_timeout", c, 0);
            done = 1;
         end
      end
      xon = 0; xoff = 0; write = 0; id = 0;
      ncyc = c;
   endtask

   function automatic void decode(int fb);
      int c;
      bit [7:0] v;
      dec.delete();
      c = 1;
      while (c <= ncyc) begin
         if (tr_tx[c] == 0) begin
            for (int k = 0; k < 8; k++) v[k] = tr_tx[c + BL*(k+1) + 1];
            dec.push_back(v);
            c += BL * fb;
         end else c++;
      end
   endfunction

   task automatic check_dec(input string nm, input int n, input logic [31:0] exp);
      logic [31:0] e;
      e = exp;
      check({nm, "_count"}, dec.size(), n);
      for (int i = 0; i < n && i < dec.size(); i++) check({nm, "_byte"}, dec[i], e[8*i +: 8]);
   endtask

   initial begin
      bit [11:0] got;
      int cnt, cnt2;

      repeat (3) @(negedge clock);
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      reset = 1;
      @(negedge clock);

      // 8N1 word, literal frame of 0xA5 and word timing
      run_word(32'h000000A5, 4'h0, 2'b00, 0, 1, 0, -1, -1, -1, -1, 0);
      got = '0;
      for (int j = 0; j < 10; j++) got[j] = tr_tx[3 + 4*j + 1];
      check("a5_frame", got, 12'b0011_0100_1010);
      check("a5_latency_pre", tr_tx[2], 1);
      check("a5_latency_start", tr_tx[3], 0);
      check("a5_busy_rise", tr_busy[1], 1);
      check("a5_busy_fall_cycle", ncyc, 171);
      decode(10);
      check_dec("a5_dec", 4, 32'h000000A5);

      // odd parity, two stop bits
      run_word(32'h00000003, 4'h0, 2'b01, 1, 1, 0, -1, -1, -1, -1, 0);
      got = '0;
      for (int j = 0; j < 12; j++) got[j] = tr_tx[3 + 4*j + 1];
      check("odd_frame", got, 12'b1110_0000_0110);
      check("odd_gap", tr_tx[52], 1);
      check("odd_next_start", tr_tx[53], 0);

      // even parity
      run_word(32'h00000003, 4'h0, 2'b10, 0, 1, 0, -1, -1, -1, -1, 0);
      check("even_parity_bit", tr_tx[40], 0);
      check("even_stop_bit", tr_tx[44], 1);

      // group skipping
      run_word(32'h44332211, 4'b1010, 2'b00, 0, 1, 0, -1, -1, -1, -1, 0);
      decode(10);
      check_dec("mask_dec", 2, 32'h00003311);

      run_word(32'h00000000, 4'b1111, 2'b00, 0, 1, 0, -1, -1, -1, -1, 0);
      cnt = 0; cnt2 = 0;
      for (int i = 1; i <= ncyc; i++) begin
         cnt  += tr_busy[i];
         cnt2 += (tr_tx[i] == 0);
      end
      check("alldis_busy_len", cnt, 6);
      check("alldis_tx_idle", cnt2, 0);

      // id alone (mask ignored), then id with write
      run_word(32'h00000000, 4'b1111, 2'b00, 0, 0, 1, -1, -1, -1, -1, 0);
      decode(10);
      check_dec("id_dec", 4, 32'h534C4131);
      run_word(32'h12345678, 4'h0, 2'b00, 0, 1, 1, -1, -1, -1, -1, 0);
      decode(10);
      check_dec("idwr_dec", 4, 32'h12345678);

      // xoff in frame 1, xon+xoff together while paused, xon later
      run_word(32'hDDCCBBAA, 4'h0, 2'b00, 0, 1, 0, 60, 135, 110, -1, 0);
      cnt = 0;
      for (int i = 85; i <= 137; i++) cnt += tr_tx[i] & tr_busy[i];
      check("pause_hold_high", cnt, 53);
      check("pause_resume_start", tr_tx[138], 0);
      decode(10);
      check_dec("pause_dec", 4, 32'hDDCCBBAA);

      // reset in the middle of frame 2, then a fresh word
      run_word(32'h11223344, 4'h0, 2'b00, 0, 1, 0, -1, -1, -1, 100, 0);
      repeat (2) @(negedge clock);
      run_word(32'h0000C35A, 4'h0, 2'b00, 0, 1, 0, -1, -1, -1, -1, 0);
      check("post_rst_start", tr_tx[3], 0);
      decode(10);
      check_dec("post_rst_dec", 4, 32'h0000C35A);

      // randomized words, modes, masks and flow control, checked by the model
      for (int r = 0; r < 12; r++) begin
         run_word($urandom, $urandom, $urandom, $urandom, ($urandom % 4) != 0, ($urandom % 3) == 0,
                  -1, -1, -1, -1, 1);
         repeat (3) @(negedge clock);
      end

      repeat (5) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
